fpga_rst_seq: RTL
=================

Name: fpga_rst_seq

Overview:
- Parametrised clock/reset supervisor that sits next to the fpga_pll MMCM wrapper and replaces its single fixed 3-flop reset synchronizer.
- Drives the MMCM RST input and qualifies LOCKED with synchronisation and a stability filter.
- Releases NUM_RST synchronous active-low resets one after another, at a fixed spacing.
- Recovers on its own from lock loss, lock timeout and software reset requests.
- Runs on a free-running reference clock, never on an MMCM output.

Parameters:
- NUM_RST, 3: number of sequenced reset outputs (>=1).
- SYNC_STAGES, 3: flops in the pll_lock synchronizer (>=2).
- LOCK_STABLE_CYC, 64: cycles the synchronised lock must stay high before the first release (>=1).
- STAGGER_CYC, 16: cycles between consecutive srst_n releases (>=1).
- LOCK_TIMEOUT_CYC, 4096: cycles allowed in WAIT_LOCK before the MMCM is reset again (>=1).
- PLL_RST_CYC, 8: cycles pll_rst is held high per MMCM reset (>=1).
- CNT_W, 8: width of the lock-loss event counter.

Ports:
- clk_in, input, 1: free-running reference clock (board 200MHz).
- arst_n, input, 1: asynchronous active-low reset.
- pll_lock, input, 1: MMCM LOCKED, asynchronous to clk_in.
- sw_rst_req, input, 1: synchronous request for a full re-sequence, level or pulse.
- pll_rst, output, 1: MMCM RST, active high.
- srst_n, output, NUM_RST: sequenced synchronous resets, active low; bit 0 is released first.
- all_rdy, output, 1: every srst_n is released and the block is in RUN.
- lock_loss_cnt, output, CNT_W: saturating count of lock-loss events.
- timeout_err, output, 1: sticky flag, at least one lock timeout has occurred.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - Assertion of arst_n is asynchronous. Deassertion takes effect on the next clk_in edge.
- Reset values:
  - pll_rst=1, srst_n=all 0, all_rdy=0, lock_loss_cnt=0, timeout_err=0.
  - FSM=PLLRST, all counters 0, synchronizer flops 0.
- All outputs are registered.
- lock_s is pll_lock after SYNC_STAGES flops. Only lock_s is used inside the block.
- PLLRST state:
  - pll_rst=1 and srst_n=all 0 for exactly PLL_RST_CYC cycles, then go to WAIT_LOCK.
  - pll_rst is 0 in every other state.
- WAIT_LOCK state:
  - Timeout counter restarts at entry.
  - lock_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT_CYC with lock_s=0: set timeout_err=1 and go to PLLRST.
  - timeout_err is cleared only by arst_n.
- STABLE state:
  - Counts consecutive cycles with lock_s=1.
  - lock_s=0 during the count: go back to WAIT_LOCK. This is a glitch; lock_loss_cnt does not change.
  - Count reaches LOCK_STABLE_CYC: go to RELEASE.
- RELEASE state:
  - srst_n[0] rises on the first RELEASE cycle.
  - srst_n[i] rises i*STAGGER_CYC cycles after srst_n[0].
  - Once high, a bit stays high until an abort.
  - After srst_n[NUM_RST-1] rises, go to RUN. all_rdy rises on the next cycle.
- RUN state:
  - all_rdy=1 and srst_n=all 1.
- Abort:
  - Trigger: lock_s=0 in RELEASE or RUN, or sw_rst_req=1 in WAIT_LOCK, STABLE, RELEASE or RUN.
  - Next cycle: srst_n=all 0, all_rdy=0, go to PLLRST.
  - Every abort uses the full PLLRST, WAIT_LOCK, STABLE, RELEASE sequence.
- sw_rst_req is ignored while in PLLRST. A level held high re-triggers after PLLRST ends.
- lock_loss_cnt:
  - Increments by 1 only when lock_s drops in RELEASE or RUN.
  - Saturates at 2^CNT_W-1.
  - Lock loss and sw_rst_req in the same cycle: one abort, one increment.
- Lock timing: with lock_s first high at cycle L in WAIT_LOCK:
  - srst_n[0] rises at L+LOCK_STABLE_CYC+1.
  - srst_n[i] rises at L+LOCK_STABLE_CYC+1+i*STAGGER_CYC.
- arst_n asserted mid-sequence: all outputs return to reset values immediately. lock_loss_cnt and timeout_err are cleared.

Test Plan:
- Nominal bring-up (defaults): deassert arst_n, raise pll_lock at cycle 20 -> pll_rst high for cycles 0-7; srst_n[0] rises 64+1 cycles after lock_s goes high; srst_n[1] 16 cycles later and srst_n[2] 32 cycles later; all_rdy 1 cycle after srst_n[2]; lock_loss_cnt=0.
- Lock glitch in STABLE: drop pll_lock for 5 cycles at stable count 30 -> stays in reset, stable count restarts from 0, lock_loss_cnt=0.
- Lock loss in RUN, three times -> srst_n=000 and all_rdy=0 one cycle after each lock_s fall; pll_rst pulses 8 cycles each time; lock_loss_cnt=3. Repeat with CNT_W=2 and 5 losses -> lock_loss_cnt=3 (saturated).
- Timeout: hold pll_lock=0 -> after 8+4096 cycles timeout_err=1 and a second 8-cycle pll_rst pulse; raise lock later -> normal release, timeout_err stays 1.
- sw_rst_req pulse mid-RELEASE with srst_n=001 -> srst_n=000 next cycle, full re-sequence, lock_loss_cnt unchanged. Same-cycle sw_rst_req + lock loss in RUN -> one PLLRST entry, lock_loss_cnt +1.
- arst_n asserted in RUN with lock_loss_cnt=2, timeout_err=1 -> immediately srst_n=000, pll_rst=1, lock_loss_cnt=0, timeout_err=0; with NUM_RST=1 the release gives all_rdy 1 cycle after srst_n[0].

Source files
------------

// File: rtl/fpga_rst_seq.sv
// Clock/reset supervisor for the fpga_pll MMCM wrapper.
// Holds the MMCM in reset, qualifies LOCKED, then releases NUM_RST
// active-low synchronous resets one after another. Lock loss, lock
// timeout and software requests all restart the full sequence.
// Runs on the free-running reference clock only.
module fpga_rst_seq #(
    parameter int NUM_RST          = 3,
    parameter int SYNC_STAGES      = 3,
    parameter int LOCK_STABLE_CYC  = 64,
    parameter int STAGGER_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 4096,
    parameter int PLL_RST_CYC      = 8,
    parameter int CNT_W            = 8
) (
    input  logic               clk_in,
    input  logic               arst_n,
    input  logic               pll_lock,
    input  logic               sw_rst_req,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] srst_n,
    output logic               all_rdy,
    output logic [CNT_W-1:0]   lock_loss_cnt,
    output logic               timeout_err
);

    // One shared phase timer, sized for the longest interval it has to count.
    localparam int MAX_AB = (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CD = (STAGGER_CYC > PLL_RST_CYC) ? STAGGER_CYC : PLL_RST_CYC;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW     = $clog2(MAX_T + 1);

    localparam logic [TW-1:0]      TMR_ZERO  = TW'(0);
    localparam logic [TW-1:0]      TMR_ONE   = TW'(1);
    localparam logic [TW-1:0]      PLL_LAST  = TW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0]      TO_LAST   = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]      STAB_LAST = TW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0]      STG_LAST  = TW'(STAGGER_CYC - 1);
    localparam logic [NUM_RST-1:0] RST_NONE  = {NUM_RST{1'b0}};
    localparam logic [NUM_RST-1:0] RST_ALL   = {NUM_RST{1'b1}};
    localparam logic [NUM_RST-1:0] RST_FIRST = NUM_RST'(1);
    localparam logic [CNT_W-1:0]   LOSS_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   LOSS_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 lock_s;
    logic                 pll_rst_q, pll_rst_d;
    logic [NUM_RST-1:0]   srst_n_q, srst_n_d;
    logic                 all_rdy_q, all_rdy_d;
    logic [CNT_W-1:0]     loss_q, loss_d;
    logic                 tout_q, tout_d;
    logic                 abort_s;
    logic                 lost_s;

    assign lock_s        = sync_q[SYNC_STAGES-1];
    assign pll_rst       = pll_rst_q;
    assign srst_n        = srst_n_q;
    assign all_rdy       = all_rdy_q;
    assign lock_loss_cnt = loss_q;
    assign timeout_err   = tout_q;

    // Bring the asynchronous MMCM LOCKED into the reference clock domain.
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    // Sequencer decisions: next phase, timer, and the registered outputs.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        srst_n_d  = srst_n_q;
        all_rdy_d = all_rdy_q;
        tout_d    = tout_q;
        pll_rst_d = 1'b0;
        abort_s   = 1'b0;
        lost_s    = 1'b0;
        case (state_q)
            ST_PLLRST: begin
                // Software requests are deliberately ignored while the MMCM is held.
                if (tmr_q == PLL_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = TMR_ZERO;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (sw_rst_req) begin
                    abort_s = 1'b1;
                end else if (lock_s) begin
                    state_d = ST_STABLE;
                    tmr_d   = TMR_ZERO;
                end else if (tmr_q == TO_LAST) begin
                    tout_d  = 1'b1;
                    abort_s = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_STABLE: begin
                // A dropout here is a glitch: retry the lock wait, no loss event.
                if (sw_rst_req) begin
                    abort_s = 1'b1;
                end else if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    tmr_d   = TMR_ZERO;
                end else if (tmr_q == STAB_LAST) begin
                    state_d  = ST_RELEASE;
                    tmr_d    = TMR_ZERO;
                    srst_n_d = RST_FIRST;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    lost_s  = 1'b1;
                    abort_s = 1'b1;
                end else if (sw_rst_req) begin
                    abort_s = 1'b1;
                end else if (srst_n_q[NUM_RST-1]) begin
                    state_d   = ST_RUN;
                    all_rdy_d = 1'b1;
                end else if (tmr_q == STG_LAST) begin
                    tmr_d    = TMR_ZERO;
                    srst_n_d = (srst_n_q << 1) | RST_FIRST;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    lost_s  = 1'b1;
                    abort_s = 1'b1;
                end else if (sw_rst_req) begin
                    abort_s = 1'b1;
                end else begin
                    srst_n_d  = RST_ALL;
                    all_rdy_d = 1'b1;
                end
            end
            default: begin
                abort_s = 1'b1;
            end
        endcase

        // Every abort restarts from a full MMCM reset.
        if (abort_s) begin
            state_d   = ST_PLLRST;
            tmr_d     = TMR_ZERO;
            srst_n_d  = RST_NONE;
            all_rdy_d = 1'b0;
            pll_rst_d = 1'b1;
        end else begin
            pll_rst_d = (state_d == ST_PLLRST);
        end
    end

    // Saturating lock-loss event counter; one event per abort at most.
    always_comb begin
        if (lost_s && (loss_q != LOSS_MAX)) begin
            loss_d = loss_q + LOSS_ONE;
        end else begin
            loss_d = loss_q;
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_PLLRST;
            tmr_q     <= TMR_ZERO;
            pll_rst_q <= 1'b1;
            srst_n_q  <= RST_NONE;
            all_rdy_q <= 1'b0;
            loss_q    <= {CNT_W{1'b0}};
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            pll_rst_q <= pll_rst_d;
            srst_n_q  <= srst_n_d;
            all_rdy_q <= all_rdy_d;
            loss_q    <= loss_d;
            tout_q    <= tout_d;
        end
    end

endmodule
